// File: rtl/r32i_pkg.sv
// Shared RV32I decode definitions: ALU function codes, major opcodes and the
// decoded control word passed from decode to execute.
package r32i_pkg;

    localparam int unsigned DATAW = 32;

    typedef logic [3:0] alu_code_t;

    localparam alu_code_t ALU_ADD  = 4'd0;
    localparam alu_code_t ALU_SLT  = 4'd1;
    localparam alu_code_t ALU_SLTU = 4'd2;
    localparam alu_code_t ALU_AND  = 4'd3;
    localparam alu_code_t ALU_OR   = 4'd4;
    localparam alu_code_t ALU_XOR  = 4'd5;
    localparam alu_code_t ALU_SLL  = 4'd6;
    localparam alu_code_t ALU_SRL  = 4'd7;
    localparam alu_code_t ALU_SRA  = 4'd8;
    localparam alu_code_t ALU_CPY  = 4'd9;
    localparam alu_code_t ALU_SUB  = 4'd10;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_code_t        alu_code;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [DATAW-1:0] imm;
        logic             a_sel;
        logic             b_sel;
        logic             reg_write;
        logic             illegal;
    } decoded_t;

    // alt selects SUB/SRA over ADD/SRL (instr[30] for register ops)
    function automatic alu_code_t funct3_alu(input logic [2:0] funct3, input logic alt);
        alu_code_t code;
        case (funct3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_comb_r32i.sv
// Combinational RV32I instruction decoder: raw instruction to control word.
module decode_comb_r32i
    import r32i_pkg::*;
(
    input  logic [DATAW-1:0] instr,
    output decoded_t         dec
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [DATAW-1:0] i_imm;
    logic [DATAW-1:0] s_imm;
    logic [DATAW-1:0] u_imm;
    logic [DATAW-1:0] shamt;
    logic             legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        dec          = '0;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        legal        = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.alu_code  = funct3_alu(funct3, funct7 == FUNCT7_ALT);
                dec.reg_write = 1'b1;
                legal = (funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OPIMM: begin
                dec.alu_code  = funct3_alu(funct3, (funct3 == 3'b101) && (funct7 == FUNCT7_ALT));
                dec.b_sel     = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = i_imm;
                if (funct3 == 3'b001) begin
                    dec.imm = shamt;
                    legal   = (funct7 == FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec.imm = shamt;
                    legal   = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                end
            end
            OPC_LUI: begin
                dec.alu_code  = ALU_CPY;
                dec.b_sel     = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = u_imm;
            end
            OPC_AUIPC: begin
                dec.alu_code  = ALU_ADD;
                dec.a_sel     = 1'b1;
                dec.b_sel     = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = u_imm;
            end
            OPC_LOAD: begin
                dec.alu_code  = ALU_ADD;
                dec.b_sel     = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = i_imm;
            end
            OPC_STORE: begin
                dec.alu_code  = ALU_ADD;
                dec.b_sel     = 1'b1;
                dec.imm       = s_imm;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words still travel downstream, but as an inert ADD
        if (!legal) begin
            dec.alu_code  = ALU_ADD;
            dec.imm       = '0;
            dec.a_sel     = 1'b0;
            dec.b_sel     = 1'b0;
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/decode_stage_r32i.sv
// Registered RV32I decode stage: combinational decode feeding a two-entry
// skid buffer with valid/ready handshakes on both sides.
module decode_stage_r32i
    import r32i_pkg::*;
#(
    parameter int unsigned dataW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [dataW-1:0] instr,
    input  logic [dataW-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_code_t        alu_code,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [dataW-1:0] imm,
    output logic             a_sel,
    output logic             b_sel,
    output logic             reg_write,
    output logic             illegal,
    output logic [dataW-1:0] pc_out
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

    skid_state_t      state, state_nx;
    decoded_t         dec, out_dec, skid_dec;
    logic [dataW-1:0] out_pc, skid_pc;
    logic             accept, xfer;
    logic             load_out_in, load_out_skid, load_skid;

    decode_comb_r32i u_decode (
        .instr (instr),
        .dec   (dec)
    );

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_nx      = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx    = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                case ({accept, xfer})
                    2'b10: begin
                        state_nx  = FULL;
                        load_skid = 1'b1;
                    end
                    2'b01:   state_nx    = EMPTY;
                    2'b11:   load_out_in = 1'b1;
                    default: state_nx    = ONE;
                endcase
            end
            FULL: begin
                if (xfer) begin
                    state_nx      = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dec  <= '0;
            out_pc   <= '0;
            skid_dec <= '0;
            skid_pc  <= '0;
        end else begin
            if (load_out_in) begin
                out_dec <= dec;
                out_pc  <= pc;
            end else if (load_out_skid) begin
                out_dec <= skid_dec;
                out_pc  <= skid_pc;
            end
            if (load_skid) begin
                skid_dec <= dec;
                skid_pc  <= pc;
            end
        end
    end

    assign alu_code  = out_dec.alu_code;
    assign rs1       = out_dec.rs1;
    assign rs2       = out_dec.rs2;
    assign rd        = out_dec.rd;
    assign imm       = out_dec.imm;
    assign a_sel     = out_dec.a_sel;
    assign b_sel     = out_dec.b_sel;
    assign reg_write = out_dec.reg_write;
    assign illegal   = out_dec.illegal;
    assign pc_out    = out_pc;

endmodule

// File: tb/tb_decode_stage_r32i.sv
// Scoreboard bench for decode_stage_r32i: directed and random instructions
// checked against a table-driven reference decoder.
module tb_decode_stage_r32i;

    typedef struct packed {
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        a_sel;
        logic        b_sel;
        logic        reg_write;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, imm, pc_out;
    logic [3:0]  alu_code;
    logic [4:0]  rs1, rs2, rd;
    logic        a_sel, b_sel, reg_write, illegal;

    int          checks = 0;
    int          passes = 0;
    exp_t        sbq[$];
    logic [31:0] pc_ctr = 32'h0000_1000;
    bit          rand_ready = 1'b0;
    logic [3:0]  f3_alu [8] = '{4'd0, 4'd6, 4'd1, 4'd2, 4'd5, 4'd7, 4'd4, 4'd3};

    always #5 clk = ~clk;

    decode_stage_r32i #(.dataW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .alu_code(alu_code), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .a_sel(a_sel), .b_sel(b_sel), .reg_write(reg_write),
        .illegal(illegal), .pc_out(pc_out)
    );

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference decoder built from the instruction-set rules
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pcv);
        exp_t        e;
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] i_imm = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] u_imm = {ins[31:12], 12'h000};
        bit          ok = 1;
        e = '0;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pcv;
        case (op)
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.alu = f3_alu[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd10;
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd8;
                e.reg_write = 1;
            end
            7'h13: begin
                e.alu = f3_alu[f3];
                if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'd8;
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : i_imm;
                e.b_sel = 1; e.reg_write = 1;
            end
            7'h37: begin e.alu = 4'd9; e.imm = u_imm; e.b_sel = 1; e.reg_write = 1; end
            7'h17: begin e.imm = u_imm; e.a_sel = 1; e.b_sel = 1; e.reg_write = 1; end
            7'h03: begin e.imm = i_imm; e.b_sel = 1; e.reg_write = 1; end
            7'h23: begin e.imm = s_imm; e.b_sel = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.alu = 4'd0; e.imm = 32'h0; e.a_sel = 0; e.b_sel = 0;
            e.reg_write = 0; e.illegal = 1;
        end
        if (e.rd == 5'd0) e.reg_write = 0;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 8))
            0, 1:    r[6:0] = 7'h33;
            2, 3:    r[6:0] = 7'h13;
            4:       r[6:0] = 7'h37;
            5:       r[6:0] = 7'h17;
            6:       r[6:0] = 7'h03;
            7:       r[6:0] = 7'h23;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0:       r[31:25] = 7'h00;
            1:       r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [31:0] ins);
        int n = 0;
        bit done = 0;
        instr = ins; pc = pc_ctr; in_valid = 1;
        while (!done) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                sbq.push_back(ref_model(ins, pc_ctr));
                done = 1;
            end
            @(negedge clk);
            if (!done && ++n > 200) begin
                check("accept_timeout", in_ready, 1);
                done = 1;
            end
        end
        in_valid = 0;
        pc_ctr += 4;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: compare the presented word with the queue head, pop on transfer
    initial begin
        exp_t act;
        @(negedge rst);
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid) begin
                act = {alu_code, rs1, rs2, rd, imm, a_sel, b_sel, reg_write, illegal, pc_out};
                if (sbq.size() == 0) check("spurious_out", out_valid, 0);
                else begin
                    check("out_word", act, sbq[0]);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] dir [7] = '{32'h002081B3, 32'h407302B3, 32'h40315093, 32'h123450B7,
                                 32'hFFF00093, 32'h00000000, 32'h80209093};
        bit accepted;
        in_valid = 0; instr = '0; pc = '0; out_ready = 0;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_code", alu_code, 0);
        check("rst_fields", {rs1, rs2, rd, imm, a_sel, b_sel, reg_write, illegal, pc_out}, 0);
        @(negedge clk);
        rst = 0;

        out_ready = 1;
        foreach (dir[i]) send(dir[i]);
        wait_drain();

        // Backpressure: two accepted, third stalls until the output drains
        out_ready = 0;
        send(32'h00A50533);
        send(32'h0FF67693);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        @(negedge clk);
        out_ready = 1; instr = 32'h00C5A733; pc = pc_ctr; in_valid = 1; accepted = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_no_gap", out_valid, 1);
            if (!accepted && in_ready) begin
                sbq.push_back(ref_model(instr, pc_ctr));
                accepted = 1;
            end
            @(negedge clk);
            if (accepted) in_valid = 0;
        end
        in_valid = 0;
        pc_ctr += 4;
        check("bp_third_accepted", accepted, 1);
        wait_drain();

        // Reset while both entries are occupied
        out_ready = 0;
        send(32'h00208033);
        send(32'h00310093);
        #2 rst = 1;
        #1;
        check("rst_full_out_valid", out_valid, 0);
        check("rst_full_in_ready", in_ready, 1);
        sbq.delete();
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        out_ready = 1;
        #1;
        check("no_stale_after_rst", out_valid, 0);
        @(negedge clk);

        rand_ready = 1;
        for (int i = 0; i < 300; i++) send(gen_instr());
        rand_ready = 0;
        out_ready = 1;
        wait_drain();
        check("all_delivered", sbq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_r32i.md
# decode_stage_r32i

Registered RV32I decode stage that turns a fetched 32-bit instruction into the control word consumed by the RV32I ALU: 4-bit ALU code, register indices, 32-bit immediate and operand selects. It sits between fetch and the register-read/execute stage. It uses a valid/ready handshake on both sides, with a two-entry skid buffer so throughput is one instruction per cycle under backpressure.

## Interface
- `dataW`, 32: instruction, PC and immediate width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetch presents `instr`/`pc`.
- `in_ready` out 1: stage can accept; registered.
- `instr` in dataW: raw instruction.
- `pc` in dataW: instruction address.
- `out_valid` out 1: decoded word valid.
- `out_ready` in 1: execute accepts.
- `alu_code` out 4: ALU function, encoding from the shared package.
- `rs1`, `rs2`, `rd` out 5 each: register indices, `instr[19:15]`, `[24:20]`, `[11:7]`.
- `imm` out dataW: decoded immediate.
- `a_sel` out 1: 1 = ALU A from `pc`, 0 = from rs1.
- `b_sel` out 1: 1 = ALU B from `imm`, 0 = from rs2.
- `reg_write` out 1: result written to `rd`; forced 0 when `rd`=0 or illegal.
- `illegal` out 1: unsupported or malformed instruction.
- `pc_out` out dataW: `pc` carried alongside the decoded word.

## Operation
- ALU codes: ADD=0, SLT=1, SLTU=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, CPY=9, SUB=10.
- Supported opcodes (`instr[6:0]`):
  - OP 0110011: `b_sel`=0, `reg_write`=1. funct3 maps as 000 ADD/SUB (`instr[30]`), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (`instr[30]`), 110 OR, 111 AND.
    - funct7 must be 0000000.
    - 0100000 is also allowed for funct3 000 and 101.
    - Anything else is illegal.
  - OP-IMM 0010011: same funct3 map, `b_sel`=1. SUB is never produced. `imm` is `instr[31:20]` sign-extended.
    - For funct3 001 and 101, `imm` is instead zero-extended `instr[24:20]`.
    - funct3 001 requires funct7 0000000.
    - funct3 101 requires 0000000 (SRL) or 0100000 (SRA).
  - LUI 0110111: CPY, `b_sel`=1, `imm`={`instr[31:12]`,12'b0}.
  - AUIPC 0010111: ADD, `a_sel`=1, `b_sel`=1, U-immediate.
  - LOAD 0000011: ADD, `b_sel`=1, I-immediate, `reg_write`=1.
  - STORE 0100011: ADD, `b_sel`=1, S-immediate {`instr[31:25]`,`instr[11:7]`} sign-extended, `reg_write`=0.
- Any other opcode, or `instr[1:0]`≠11, or a funct7 violation sets `illegal`=1, `alu_code`=ADD, `imm`=0, `a_sel`=`b_sel`=`reg_write`=0. An illegal word is still passed downstream; it is never dropped.
- Skid buffer states:
  - EMPTY: output register empty.
  - ONE: output register full.
  - FULL: output and skid registers full.
- State transitions:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on output transfer with no accept.
  - ONE → FULL on accept with no output transfer.
  - ONE stays ONE on simultaneous accept and transfer.
  - FULL → ONE on output transfer; the skid entry moves to the output register.
- `in_ready` = (state≠FULL). Accepts occur only when `in_valid`&`in_ready`.

## Timing
- Decode is combinational on the input; the result is registered.
- Latency: an instruction accepted on edge N is on the outputs after edge N with `out_valid`=1.
- Throughput is one per cycle while `out_ready`=1.
- Outputs are held stable while `out_valid`&!`out_ready`.
- Entries leave in order; no entry is lost or duplicated.
- Reset values, asynchronous, including mid-transfer: state EMPTY, `out_valid`=0, `in_ready`=1, `alu_code`=ADD, all other outputs 0. Both entries are discarded.
- First accept is possible on the first rising edge after `rst` falls.

## Structure
- Package `r32i_pkg`: ALU code constants, opcode constants, an `alu_code_t` 4-bit typedef, and a `decoded_t` struct holding all decoded fields.
- Sub-module `decode_comb_r32i`: pure combinational instr → `decoded_t`. The stage instantiates it once, before the skid buffer.

## Test plan
- 0x002081B3 (add x3,x1,x2) with `out_ready`=1 → next cycle ADD, rs1=1, rs2=2, rd=3, `b_sel`=0, `reg_write`=1.
- 0x407302B3 (sub x5,x6,x7) → SUB, rd=5. 0x40315093 (srai x1,x2,3) → SRA, `imm`=3, `b_sel`=1.
- 0x123450B7 (lui x1,0x12345) → CPY, `imm`=0x12345000. 0xFFF00093 (addi x1,x0,-1) → `imm`=0xFFFFFFFF.
- 0x00000000 and 0x80209093 (slli with bad funct7) → `illegal`=1, `reg_write`=0, still delivered.
- Backpressure: hold `out_ready`=0 and offer 3 instructions.
  - First two accepted, then `in_ready`=0.
  - Raise `out_ready`: all three exit in order, with no gap once streaming.
- Assert `rst` while state is FULL → `out_valid`=0 and `in_ready`=1 immediately; no stale entry appears afterwards.
